// File: rtl/ram_pkg.sv
// ram_pkg: shared state type, read-during-write policy constants and lane helper
package ram_pkg;
  typedef enum logic {RAM_CLEAR = 1'b0, RAM_READY = 1'b1} ram_state_e;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST = 1;
  function automatic int lane_count(input int word_width, input int lane_width);
    return word_width / lane_width;
  endfunction
endpackage

// File: rtl/ram_clear_sequencer.sv
// ram_clear_sequencer: zero-fill walker that owns busy and the clear address after reset
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int ADDRESS_SIZE = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    busy_o,
  output logic                    clear_write_enable_o,
  output logic [ADDRESS_SIZE-1:0] clear_address_o
);
  localparam int MEM_DEPTH = 2 ** ADDRESS_SIZE;
  ram_state_e state_q, state_d;
  logic [ADDRESS_SIZE:0] addr_q, addr_d;
  // state and counter registers; reset restarts the pass from address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RAM_CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  // leave CLEAR after the edge that zeroes the last word; the extra counter bit avoids wrap
  always_comb begin
    state_d = (state_q == RAM_CLEAR && addr_q == (ADDRESS_SIZE + 1)'(MEM_DEPTH - 1)) ? RAM_READY : state_q;
    addr_d  = (state_q == RAM_CLEAR) ? addr_q + (ADDRESS_SIZE + 1)'(1) : addr_q;
  end
  // memory is left untouched in a cycle where reset is sampled
  always_comb begin
    busy_o               = (state_q == RAM_CLEAR);
    clear_write_enable_o = (state_q == RAM_CLEAR) && !reset;
    clear_address_o      = addr_q[ADDRESS_SIZE-1:0];
  end
endmodule

// File: rtl/ram_dual_port.sv
// ram_dual_port: one-read/one-write RAM with lane masks, RDW policy and clear-after-reset
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 11,
  parameter int MEM_WORD_SIZE = 64,
  parameter int LANE_WIDTH    = 8,
  parameter int RDW_MODE      = RDW_WRITE_FIRST,
  localparam int NUM_LANES    = lane_count(MEM_WORD_SIZE, LANE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDRESS_SIZE-1:0]  write_address,
  input  logic [MEM_WORD_SIZE-1:0] write_data,
  input  logic [NUM_LANES-1:0]     write_mask,
  input  logic                     read_enable,
  input  logic [ADDRESS_SIZE-1:0]  read_address,
  output logic [MEM_WORD_SIZE-1:0] read_data,
  output logic                     read_valid,
  output logic                     busy
);
  localparam int MEM_DEPTH = 2 ** ADDRESS_SIZE;
  logic [MEM_WORD_SIZE-1:0] mem [MEM_DEPTH];
  logic [MEM_WORD_SIZE-1:0] merged, read_data_q, read_data_d;
  logic [ADDRESS_SIZE-1:0] clear_address;
  logic clear_write_enable, wr_go, rd_go, bypass, read_valid_q;
  ram_clear_sequencer #(.ADDRESS_SIZE(ADDRESS_SIZE)) u_clear (
    .clk                  (clk),
    .reset                (reset),
    .busy_o               (busy),
    .clear_write_enable_o (clear_write_enable),
    .clear_address_o      (clear_address)
  );
  // lane merge of incoming data over the currently stored word
  always_comb begin
    merged = mem[write_address];
    for (int i = 0; i < NUM_LANES; i++)
      if (write_mask[i]) merged[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
  end
  // request qualification and same-address forwarding for write-first mode
  always_comb begin
    wr_go       = write_enable && !busy && !reset;
    rd_go       = read_enable && !busy && !reset;
    bypass      = (RDW_MODE == RDW_WRITE_FIRST) && wr_go && (write_address == read_address);
    read_data_d = rd_go ? (bypass ? merged : mem[read_address]) : read_data_q;
  end
  // memory write port shared between the clear walker and user writes
  always_ff @(posedge clk) begin
    if (clear_write_enable) mem[clear_address] <= '0;
    else if (wr_go) mem[write_address] <= merged;
  end
  // registered read data and one-cycle valid
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= rd_go;
    end
  end
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
endmodule

// File: tb/tb_ram_dual_port.sv
// tb_ram_dual_port: directed checks of a write-first and a read-first instance driven in lockstep
module tb_ram_dual_port;
  logic clk = 1'b0;
  logic reset, write_enable, read_enable;
  logic [3:0] write_address, read_address, write_mask;
  logic [31:0] write_data, rd0, rd1;
  logic rv0, rv1, busy0, busy1;
  int compared = 0, mismatched = 0;
  int n0, n1;
  always #5 clk = ~clk;
  ram_dual_port #(.ADDRESS_SIZE(4), .MEM_WORD_SIZE(32), .LANE_WIDTH(8), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .write_mask(write_mask), .read_enable(read_enable),
    .read_address(read_address), .read_data(rd0), .read_valid(rv0), .busy(busy0));
  ram_dual_port #(.ADDRESS_SIZE(4), .MEM_WORD_SIZE(32), .LANE_WIDTH(8), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .write_mask(write_mask), .read_enable(read_enable),
    .read_address(read_address), .read_data(rd1), .read_valid(rv1), .busy(busy1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    write_enable = 1'b1;
    write_address = a;
    write_data = d;
    write_mask = m;
  endtask
  task automatic rd(input logic [3:0] a);
    read_enable = 1'b1;
    read_address = a;
  endtask
  task automatic idle();
    write_enable = 1'b0;
    read_enable = 1'b0;
  endtask
  task automatic count_clear(input string tag);
    n0 = 0;
    while ((busy0 || busy1) && n0 < 100) begin
      tick();
      n0++;
      chk({tag, "_rv0"}, {31'd0, rv0}, 32'd0);
      chk({tag, "_rd0"}, rd0, 32'd0);
    end
    chk({tag, "_busy_cycles"}, n0, 32'd16);
    chk({tag, "_busy1_low"}, {31'd0, busy1}, 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    idle();
    write_address = '0;
    read_address = '0;
    write_data = '0;
    write_mask = '0;
    rd(4'd0);
    tick();
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd1);
    chk("rst_rv", {30'd0, rv0, rv1}, 32'd0);
    chk("rst_rd", rd0 | rd1, 32'd0);
    reset = 1'b0;
    wr(4'd2, 32'hFFFF_FFFF, 4'hF);
    rd(4'd2);
    count_clear("clr1");
    idle();
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      tick();
      chk($sformatf("zero_rv_%0d", a), {30'd0, rv0, rv1}, 32'd3);
      chk($sformatf("zero_rd_%0d", a), rd0 | rd1, 32'd0);
    end
    idle();
    tick();
    chk("zero_rv_drop", {30'd0, rv0, rv1}, 32'd0);
    wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
    tick();
    wr(4'd3, 32'h1122_3344, 4'b0101);
    tick();
    idle();
    rd(4'd3);
    tick();
    chk("mask_rd0", rd0, 32'hDE22_BE44);
    chk("mask_rd1", rd1, 32'hDE22_BE44);
    wr(4'd5, 32'hCAFE_F00D, 4'b1111);
    rd(4'd5);
    tick();
    chk("rdw_wf", rd0, 32'hCAFE_F00D);
    chk("rdw_rf", rd1, 32'h0000_0000);
    write_enable = 1'b0;
    tick();
    chk("rdw_after0", rd0, 32'hCAFE_F00D);
    chk("rdw_after1", rd1, 32'hCAFE_F00D);
    wr(4'd5, 32'h1234_5678, 4'b0011);
    tick();
    chk("rdw_mask_wf", rd0, 32'hCAFE_5678);
    chk("rdw_mask_rf", rd1, 32'hCAFE_F00D);
    wr(4'd5, 32'hFFFF_FFFF, 4'b0000);
    tick();
    chk("nomask_wf", rd0, 32'hCAFE_5678);
    chk("nomask_rf", rd1, 32'hCAFE_5678);
    idle();
    wr(4'd0, 32'h0BAD_F00D, 4'hF);
    tick();
    wr(4'd1, 32'h1234_5678, 4'hF);
    tick();
    wr(4'd2, 32'h8765_4321, 4'hF);
    tick();
    wr(4'd8, 32'h8888_8888, 4'hF);
    rd(4'd0);
    tick();
    chk("b2b_rv0", {30'd0, rv0, rv1}, 32'd3);
    chk("b2b_rd0", rd0, 32'h0BAD_F00D);
    wr(4'd9, 32'hA5A5_A5A5, 4'hF);
    rd(4'd1);
    tick();
    chk("b2b_rv1", {30'd0, rv0, rv1}, 32'd3);
    chk("b2b_rd1", rd1, 32'h1234_5678);
    wr(4'd10, 32'hAAAA_5555, 4'hF);
    rd(4'd2);
    tick();
    chk("b2b_rv2", {30'd0, rv0, rv1}, 32'd3);
    chk("b2b_rd2", rd0, 32'h8765_4321);
    idle();
    tick();
    chk("hold_rv", {30'd0, rv0, rv1}, 32'd0);
    chk("hold_rd0", rd0, 32'h8765_4321);
    tick();
    chk("hold_rd1", rd1, 32'h8765_4321);
    rd(4'd9);
    tick();
    chk("stream_9", rd0, 32'hA5A5_A5A5);
    rd(4'd10);
    tick();
    chk("stream_10", rd1, 32'hAAAA_5555);
    reset = 1'b1;
    wr(4'd4, 32'h1111_1111, 4'hF);
    rd(4'd9);
    tick();
    chk("rst2_rv", {30'd0, rv0, rv1}, 32'd0);
    chk("rst2_rd", rd0 | rd1, 32'd0);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 7; i++) tick();
    chk("mid_busy", {30'd0, busy0, busy1}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_clear("clr2");
    idle();
    rd(4'd9);
    tick();
    chk("rezero_9_rd0", rd0, 32'd0);
    chk("rezero_9_rd1", rd1, 32'd0);
    rd(4'd3);
    tick();
    chk("rezero_3", rd0 | rd1, 32'd0);
    chk("rezero_rv", {30'd0, rv0, rv1}, 32'd3);
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
